// File: rtl/rtc_alarm_core.sv
// Timekeeping and alarm core: seconds prescaler, 12h/24h time of day with manual adjust,
// NUM_ALARMS alarm channels with snooze/timeout, and a tone-gated buzzer.
module rtc_alarm_core #(
  parameter int CLK_HZ         = 31_250_000,
  parameter int TONE_HZ        = 3125,
  parameter int NUM_ALARMS     = 2,
  parameter int HOURS_MAX      = 12,
  parameter int ALM_MIN_STEP   = 10,
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60,
  localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      inc_sec,
  input  logic                      inc_min,
  input  logic                      inc_hour,
  input  logic [AW-1:0]             alm_sel,
  input  logic                      alm_inc_min,
  input  logic                      alm_inc_hour,
  input  logic                      alm_toggle,
  input  logic                      snooze,
  input  logic                      dismiss,
  output logic [5:0]                seconds,
  output logic [5:0]                minutes,
  output logic [4:0]                hours,
  output logic [6*NUM_ALARMS-1:0]   alm_min,
  output logic [5*NUM_ALARMS-1:0]   alm_hour,
  output logic [NUM_ALARMS-1:0]     alm_en,
  output logic [NUM_ALARMS-1:0]     ringing,
  output logic                      sec_tick,
  output logic                      half_sec,
  output logic                      buzzer
);

  localparam int PW           = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int HALF_TONE    = (CLK_HZ / (2 * TONE_HZ) > 0) ? CLK_HZ / (2 * TONE_HZ) : 1;
  localparam int TW           = (HALF_TONE > 1) ? $clog2(HALF_TONE) : 1;
  localparam int SNOOZE_TICKS = SNOOZE_MIN * 60;
  localparam int RW           = (RING_TIMEOUT_S > 0) ? $clog2(RING_TIMEOUT_S + 1) : 1;
  localparam int SW           = (SNOOZE_TICKS > 0) ? $clog2(SNOOZE_TICKS + 1) : 1;

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} chState_e;

  logic [PW-1:0] presc_q;
  logic          sec_tick_q;
  logic          adv_q;
  logic [TW-1:0] tone_cnt_q;
  logic          tone_q;
  logic          buzzer_q;
  logic          any_inc;

  logic [5:0] sec_q, sec_d;
  logic [5:0] min_q, min_d;
  logic [4:0] hour_q, hour_d;

  chState_e                state_q    [NUM_ALARMS];
  logic [5:0]              alm_min_q  [NUM_ALARMS];
  logic [4:0]              alm_hour_q [NUM_ALARMS];
  logic [RW-1:0]           ring_cnt_q [NUM_ALARMS];
  logic [SW-1:0]           snz_cnt_q  [NUM_ALARMS];
  logic [NUM_ALARMS-1:0]   alm_en_q;
  logic [NUM_ALARMS-1:0]   ringing_q;
  logic [NUM_ALARMS-1:0]   trig;
  logic [NUM_ALARMS-1:0]   sel_hit;

  function automatic logic [5:0] wrap60(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] wrapHour(input logic [4:0] v);
    return (v == 5'(HOURS_MAX - 1)) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [5:0] addStep(input logic [5:0] v);
    logic [6:0] s;
    s = {1'b0, v} + 7'(ALM_MIN_STEP % 60);
    return (s >= 7'd60) ? 6'(s - 7'd60) : s[5:0];
  endfunction

  assign any_inc = inc_sec | inc_min | inc_hour;

  // adv_q marks the cycle after a tick that really advanced the time; alarms only fire then,
  // so a manual set that lands on the alarm time never triggers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q    <= '0;
      sec_tick_q <= 1'b0;
      adv_q      <= 1'b0;
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
      buzzer_q   <= 1'b0;
    end else begin
      if (presc_q == PW'(CLK_HZ - 1)) presc_q <= '0;
      else                            presc_q <= presc_q + PW'(1);
      sec_tick_q <= (presc_q == PW'(CLK_HZ - 1));
      adv_q      <= sec_tick_q & ~any_inc;
      if (tone_cnt_q == TW'(HALF_TONE - 1)) begin
        tone_cnt_q <= '0;
        tone_q     <= ~tone_q;
      end else begin
        tone_cnt_q <= tone_cnt_q + TW'(1);
      end
      buzzer_q <= (|ringing_q) & half_sec & tone_q;
    end
  end

  always_comb begin
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    if (sec_tick_q && !any_inc) begin
      sec_d = wrap60(sec_q);
      if (sec_q == 6'd59) begin
        min_d = wrap60(min_q);
        if (min_q == 6'd59) hour_d = wrapHour(hour_q);
      end
    end else begin
      if (inc_sec)  sec_d  = wrap60(sec_q);
      if (inc_min)  min_d  = wrap60(min_q);
      if (inc_hour) hour_d = wrapHour(hour_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= '0;
    end else begin
      sec_q  <= sec_d;
      min_q  <= min_d;
      hour_q <= hour_d;
    end
  end

  always_comb begin
    trig     = '0;
    sel_hit  = '0;
    alm_min  = '0;
    alm_hour = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      sel_hit[i] = (alm_sel == AW'(i));
      trig[i]    = alm_en_q[i] & adv_q & (sec_q == 6'd0) &
                   (hour_q == alm_hour_q[i]) & (min_q == alm_min_q[i]);
      alm_min[6*i +: 6]  = alm_min_q[i];
      alm_hour[5*i +: 5] = alm_hour_q[i];
    end
  end

  // Per-channel FSM; disabling a channel overrides everything, then dismiss beats snooze.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alm_en_q  <= '0;
      ringing_q <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        state_q[i]    <= IDLE;
        alm_min_q[i]  <= '0;
        alm_hour_q[i] <= '0;
        ring_cnt_q[i] <= '0;
        snz_cnt_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (alm_inc_min && sel_hit[i])  alm_min_q[i]  <= addStep(alm_min_q[i]);
        if (alm_inc_hour && sel_hit[i]) alm_hour_q[i] <= wrapHour(alm_hour_q[i]);
        if (alm_toggle && sel_hit[i])   alm_en_q[i]   <= ~alm_en_q[i];
        if (alm_toggle && sel_hit[i] && alm_en_q[i]) begin
          state_q[i]   <= IDLE;
          ringing_q[i] <= 1'b0;
        end else begin
          case (state_q[i])
            IDLE: begin
              if (trig[i]) begin
                state_q[i]    <= RINGING;
                ring_cnt_q[i] <= '0;
                ringing_q[i]  <= 1'b1;
              end
            end
            RINGING: begin
              if (dismiss) begin
                state_q[i]   <= IDLE;
                ringing_q[i] <= 1'b0;
              end else if (snooze) begin
                state_q[i]   <= SNOOZED;
                snz_cnt_q[i] <= SW'(SNOOZE_TICKS);
                ringing_q[i] <= 1'b0;
              end else if (sec_tick_q) begin
                if (ring_cnt_q[i] == RW'(RING_TIMEOUT_S - 1)) begin
                  state_q[i]   <= IDLE;
                  ringing_q[i] <= 1'b0;
                end else begin
                  ring_cnt_q[i] <= ring_cnt_q[i] + RW'(1);
                end
              end
            end
            SNOOZED: begin
              if (dismiss) begin
                state_q[i] <= IDLE;
              end else if (sec_tick_q) begin
                if (snz_cnt_q[i] <= SW'(1)) begin
                  state_q[i]    <= RINGING;
                  ring_cnt_q[i] <= '0;
                  ringing_q[i]  <= 1'b1;
                end else begin
                  snz_cnt_q[i] <= snz_cnt_q[i] - SW'(1);
                end
              end
            end
            default: begin
              state_q[i]   <= IDLE;
              ringing_q[i] <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign seconds  = sec_q;
  assign minutes  = min_q;
  assign hours    = hour_q;
  assign alm_en   = alm_en_q;
  assign ringing  = ringing_q;
  assign sec_tick = sec_tick_q;
  assign half_sec = (presc_q < PW'(CLK_HZ / 2));
  assign buzzer   = buzzer_q;

endmodule

// File: tb/tb_rtc_alarm_core.sv
// Directed bench for rtc_alarm_core: a 12h/2-channel instance for time and alarm behaviour,
// plus a 24h/3-channel instance for hour wrap and out-of-range channel select.
module tb_rtc_alarm_core;

  localparam int CLK_HZ = 100;
  localparam int TONE_HZ = 10;
  localparam int SNOOZE_MIN = 1;
  localparam int RING_T = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic inc_sec = 1'b0, inc_min = 1'b0, inc_hour = 1'b0;
  logic alm_sel = 1'b0, alm_inc_min = 1'b0, alm_inc_hour = 1'b0, alm_toggle = 1'b0;
  logic snooze = 1'b0, dismiss = 1'b0;
  logic [1:0] alm_sel24 = 2'd0;
  logic alm_inc_min24 = 1'b0;

  logic [5:0] seconds, minutes;
  logic [4:0] hours;
  logic [11:0] alm_min;
  logic [9:0] alm_hour;
  logic [1:0] alm_en, ringing;
  logic sec_tick, half_sec, buzzer;

  logic [5:0] sec24, min24;
  logic [4:0] hour24;
  logic [17:0] almMin24;
  logic [14:0] almHour24;
  logic [2:0] almEn24, ring24;
  logic tick24, half24, buzz24;

  rtc_alarm_core #(.CLK_HZ(CLK_HZ), .TONE_HZ(TONE_HZ), .NUM_ALARMS(2), .HOURS_MAX(12),
                   .ALM_MIN_STEP(10), .SNOOZE_MIN(SNOOZE_MIN), .RING_TIMEOUT_S(RING_T)) dut12 (
    .clk(clk), .reset(reset), .inc_sec(inc_sec), .inc_min(inc_min), .inc_hour(inc_hour),
    .alm_sel(alm_sel), .alm_inc_min(alm_inc_min), .alm_inc_hour(alm_inc_hour),
    .alm_toggle(alm_toggle), .snooze(snooze), .dismiss(dismiss),
    .seconds(seconds), .minutes(minutes), .hours(hours), .alm_min(alm_min),
    .alm_hour(alm_hour), .alm_en(alm_en), .ringing(ringing), .sec_tick(sec_tick),
    .half_sec(half_sec), .buzzer(buzzer));

  rtc_alarm_core #(.CLK_HZ(CLK_HZ), .TONE_HZ(TONE_HZ), .NUM_ALARMS(3), .HOURS_MAX(24),
                   .ALM_MIN_STEP(10), .SNOOZE_MIN(SNOOZE_MIN), .RING_TIMEOUT_S(RING_T)) dut24 (
    .clk(clk), .reset(reset), .inc_sec(inc_sec), .inc_min(inc_min), .inc_hour(inc_hour),
    .alm_sel(alm_sel24), .alm_inc_min(alm_inc_min24), .alm_inc_hour(1'b0),
    .alm_toggle(1'b0), .snooze(1'b0), .dismiss(1'b0),
    .seconds(sec24), .minutes(min24), .hours(hour24), .alm_min(almMin24),
    .alm_hour(almHour24), .alm_en(almEn24), .ringing(ring24), .sec_tick(tick24),
    .half_sec(half24), .buzzer(buzz24));

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;
  int edges = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) edges = 0;
    else       edges = edges + 1;
  end

  typedef struct {
    logic        sel;
    logic        im;
    logic        ih;
    logic        tg;
    logic [11:0] expMin;
    logic [9:0]  expHour;
    logic [1:0]  expEn;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input logic sel, input logic im, input logic ih, input logic tg,
                              input int eMin, input int eHour, input int eEn);
    vec_t v;
    v.sel = sel; v.im = im; v.ih = ih; v.tg = tg;
    v.expMin = 12'(eMin); v.expHour = 10'(eHour); v.expEn = 2'(eEn);
    return v;
  endfunction

  function automatic int tm(input int h, input int m, input int s);
    return h * 10000 + m * 100 + s;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic setTime(input int h, input int m, input int s);
    int n;
    n = (h > m) ? h : m;
    n = (n > s) ? n : s;
    for (int i = 0; i < n; i++) begin
      inc_hour = (i < h);
      inc_min  = (i < m);
      inc_sec  = (i < s);
      step(1);
    end
    inc_hour = 1'b0; inc_min = 1'b0; inc_sec = 1'b0;
  endtask

  task automatic waitTick();
    int k;
    k = 0;
    @(negedge clk);
    while (!sec_tick && k < 2 * CLK_HZ) begin
      @(negedge clk);
      k++;
    end
    checkOutput("tick_wait", sec_tick, 1);
  endtask

  task automatic applyStimulus(input vec_t v);
    alm_sel = v.sel; alm_inc_min = v.im; alm_inc_hour = v.ih; alm_toggle = v.tg;
    step(1);
    alm_inc_min = 1'b0; alm_inc_hour = 1'b0; alm_toggle = 1'b0;
  endtask

  task automatic setupAlarms();
    doReset();
    alm_sel = 1'b0; alm_inc_min = 1'b1;
    step(1);
    alm_sel = 1'b1;
    step(1);
    alm_inc_min = 1'b0; alm_toggle = 1'b1;
    step(1);
    alm_toggle = 1'b0;
  endtask

  // Both channels at 00:10, only channel 1 enabled; returns one cycle after it starts ringing.
  task automatic setupRing();
    setupAlarms();
    setTime(0, 9, 59);
    waitTick();
    step(1);
    checkOutput("ring_time", tm(hours, minutes, seconds), tm(0, 10, 0));
    checkOutput("ring_pre", ringing, 0);
    step(1);
    checkOutput("ring_start", ringing, 2);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int prevRing, prevEdges, expBuzz, buzzOnes, k;

    vecs[0]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 10,  0,  0);
    vecs[1]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 20,  0,  0);
    vecs[2]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 30,  0,  0);
    vecs[3]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 40,  0,  0);
    vecs[4]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 50,  0,  0);
    vecs[5]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 0,   0,  0);
    vecs[6]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 0,   32, 0);
    vecs[7]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 640, 64, 0);
    vecs[8]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 640, 64, 1);
    vecs[9]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 640, 64, 3);
    vecs[10] = mk(1'b0, 1'b0, 1'b0, 1'b1, 640, 64, 2);

    reset = 1'b1;
    step(2);
    checkOutput("rst_time", tm(hours, minutes, seconds), 0);
    checkOutput("rst_alarm", {alm_min, alm_hour, alm_en, ringing}, 0);
    checkOutput("rst_flags", {sec_tick, half_sec, buzzer}, 3'b010);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_min", i), alm_min, vecs[i].expMin);
      checkOutput($sformatf("vec%0d_hour", i), alm_hour, vecs[i].expHour);
      checkOutput($sformatf("vec%0d_en", i), alm_en, vecs[i].expEn);
    end

    alm_sel24 = 2'd3; alm_inc_min24 = 1'b1;
    step(1);
    checkOutput("sel_out_of_range", almMin24, 0);
    alm_sel24 = 2'd2;
    step(1);
    alm_inc_min24 = 1'b0;
    checkOutput("sel_ch2", almMin24, 10 << 12);

    setTime(12, 0, 0);
    checkOutput("hour12_24h", hour24, 12);
    checkOutput("hour12_12h", hours, 0);
    setTime(11, 59, 59);
    checkOutput("pre_wrap_12h", tm(hours, minutes, seconds), tm(11, 59, 59));
    checkOutput("pre_wrap_24h", tm(hour24, min24, sec24), tm(23, 59, 59));
    waitTick();
    step(1);
    checkOutput("wrap_12h", tm(hours, minutes, seconds), 0);
    checkOutput("wrap_24h", tm(hour24, min24, sec24), 0);
    checkOutput("tick_one_cycle", sec_tick, 0);
    checkOutput("half_first", half_sec, 1);

    setTime(0, 0, 59);
    checkOutput("half_second", half_sec, 0);
    checkOutput("at_59", tm(hours, minutes, seconds), tm(0, 0, 59));
    waitTick();
    inc_min = 1'b1;
    step(1);
    inc_min = 1'b0;
    checkOutput("tick_dropped", tm(hours, minutes, seconds), tm(0, 1, 59));
    waitTick();
    step(1);
    checkOutput("carry_min", tm(hours, minutes, seconds), tm(0, 2, 0));
    checkOutput("carry_min_24h", tm(hour24, min24, sec24), tm(0, 2, 0));

    setupRing();
    buzzOnes = 0;
    for (int c = 0; c < 100; c++) begin
      prevRing  = (ringing != 0) ? 1 : 0;
      prevEdges = edges;
      step(1);
      expBuzz = prevRing & (((prevEdges % CLK_HZ) < CLK_HZ / 2) ? 1 : 0) & ((prevEdges / 5) % 2);
      checkOutput($sformatf("buzz_c%0d", c), buzzer, expBuzz);
      buzzOnes += buzzer;
    end
    checkOutput("buzz_active", (buzzOnes > 0) ? 1 : 0, 1);

    snooze = 1'b1;
    step(1);
    snooze = 1'b0;
    checkOutput("snoozed", ringing, 0);
    for (int t = 1; t <= 60; t++) begin
      waitTick();
      step(1);
      if (t == 59) checkOutput("snooze_59", ringing, 0);
    end
    checkOutput("snooze_expire", ringing, 2);
    for (int t = 1; t <= 3; t++) begin
      waitTick();
      step(1);
      if (t == 2) checkOutput("timeout_2", ringing, 2);
    end
    checkOutput("timeout_3", ringing, 0);

    setupRing();
    dismiss = 1'b1;
    step(1);
    dismiss = 1'b0;
    checkOutput("dismissed", ringing, 0);
    step(1);
    checkOutput("dismiss_buzz", buzzer, 0);
    waitTick();
    step(2);
    checkOutput("no_retrigger", ringing, 0);

    setupRing();
    alm_sel = 1'b1; alm_toggle = 1'b1;
    step(1);
    alm_toggle = 1'b0;
    checkOutput("toggle_ring", ringing, 0);
    checkOutput("toggle_en", alm_en, 0);

    setupRing();
    snooze = 1'b1; dismiss = 1'b1;
    step(1);
    snooze = 1'b0; dismiss = 1'b0;
    checkOutput("both_ring", ringing, 0);
    for (int t = 1; t <= 61; t++) begin
      waitTick();
      step(1);
    end
    checkOutput("both_idle", ringing, 0);

    setupAlarms();
    setTime(0, 9, 0);
    waitTick();
    inc_min = 1'b1;
    step(1);
    inc_min = 1'b0;
    checkOutput("manual_match", tm(hours, minutes, seconds), tm(0, 10, 0));
    step(3);
    checkOutput("manual_no_trig", ringing, 0);

    setupRing();
    step(5);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checkOutput("mid_rst_time", tm(hours, minutes, seconds), 0);
    checkOutput("mid_rst_alarm", {alm_min, alm_hour, alm_en, ringing}, 0);
    checkOutput("mid_rst_flags", {sec_tick, half_sec, buzzer}, 3'b010);
    @(negedge clk);
    reset = 1'b0;
    k = 0;
    while (!sec_tick && k < 3 * CLK_HZ) begin
      @(negedge clk);
      k++;
    end
    checkOutput("first_tick", k, CLK_HZ);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
